// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronizer, mid-bit sampling FSM, valid/ready output with overrun.
// Define UART_RX_MAJORITY_EN to vote each bit from three samples (counter values 2, 1, 0).
module uart_rx_cfg #(
  parameter int BIT_CYCLES  = 434,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [15:0] RELOAD = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] HALF   = 16'(BIT_CYCLES / 2);

  logic                 sync1_q, sync2_q;
  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 bit_val, done, ferr_next;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  always_comb begin
    maj_d = maj_q;
    if (cnt_q == 16'd2) maj_d[1] = sync2_q;
    if (cnt_q == 16'd1) maj_d[0] = sync2_q;
    bit_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & sync2_q) | (maj_q[0] & sync2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) maj_q <= 2'b11;
    else        maj_q <= maj_d;
  end
`else
  assign bit_val = sync2_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    ferr_next = ferr_q;
    done      = 1'b0;
    if (state_q == IDLE) begin
      if (!sync2_q) begin
        state_d = START;
        cnt_d   = HALF;
      end
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = RELOAD;
      case (state_q)
        START: begin
          if (bit_val) state_d = IDLE;
          else begin
            state_d = DATA;
            idx_d   = 4'd0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_BITS; i++)
            if (idx_q == 4'(i)) shift_d[i] = bit_val;
          if (idx_q == 4'(DATA_BITS - 1)) begin
            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        PARITY: begin
          perr_d  = (PARITY_MODE == 2) ? ~(bit_val ^ (^shift_q)) : (bit_val ^ (^shift_q));
          state_d = STOP;
          idx_d   = 4'd0;
        end
        STOP: begin
          ferr_next = ferr_q | ~bit_val;
          ferr_d    = ferr_next;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completed word lands only when the holding register is free or being read this cycle.
  always_comb begin
    rx_valid_d   = rx_valid_q;
    rx_data_d    = rx_data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d   = 1'b1;
        rx_data_d    = shift_d;
        frame_err_d  = ferr_next;
        parity_err_d = perr_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      idx_q        <= 4'd0;
      shift_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= rx_serial;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receiver configs, expected words queued at send time.
module tb_uart_rx_cfg;
  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] line, rdy, vld, fe, pe, ovr;
  logic [7:0] d0;
  logic [6:0] d1, d2;

  always #5 clk = ~clk;

  uart_rx_cfg #(.BIT_CYCLES(BC), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .rx_serial(line[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .rx_data(d0), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]));
  uart_rx_cfg #(.BIT_CYCLES(BC), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst_n(rst_n), .rx_serial(line[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .rx_data(d1), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]));
  uart_rx_cfg #(.BIT_CYCLES(BC), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rst_n(rst_n), .rx_serial(line[2]), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .rx_data(d2), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ovr[2]));

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0, nerr = 0, vhi0 = 0, novr = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(int k, logic [8:0] d, logic f, logic p);
    sbq.push_back('{k, d, f, p});
  endtask

  function automatic logic [10:0] word(int k);
    case (k)
      0:       return {fe[0], pe[0], 1'b0, d0};
      1:       return {fe[1], pe[1], 2'b0, d1};
      default: return {fe[2], pe[2], 2'b0, d2};
    endcase
  endfunction

  task automatic idle(int k, int n);
    line[k] = 1'b1;
    tick(n);
  endtask

  // One frame, cycle by cycle; rdy_at/abort_at are cycle offsets (-1 = unused).
  task automatic send(int k, int nb, logic [8:0] d, bit has_par, logic pbit, logic stop,
                      bit glitch, int rdy_at, int abort_at);
    logic [11:0] bits;
    int          nbit;
    nbit = nb + 2 + int'(has_par);
    bits = '0;
    for (int i = 0; i < nb; i++) bits[1+i] = d[i];
    if (has_par) bits[nb+1] = pbit;
    bits[nbit-1] = stop;
    for (int n = 0; n < nbit * BC; n++) begin
      int   j;
      int   c;
      logic v;
      j = n / BC;
      c = n % BC;
      v = bits[j];
      if (glitch && j >= 1 && j <= nb && c == 8) v = ~v;
      line[k] = v;
      if (n == rdy_at) rdy[k] = 1'b1;
      if (n == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      tick(1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    line  = '1;
    rdy   = '1;

    fork
      forever begin
        @(negedge clk);
        if (vld[0]) vhi0++;
        novr += int'(ovr[0]) + int'(ovr[1]) + int'(ovr[2]);
        for (int k = 0; k < 3; k++) begin
          if (vld[k] && rdy[k]) begin
            if (sbq.size() == 0) begin
              nvec++;
              nerr++;
              $error("FAIL unexpected_word inst %0d: got %0h want none", k, word(k));
            end else begin
              exp_t e;
              e = sbq.pop_front();
              chk("word_inst", k, e.inst);
              chk("word", {21'b0, word(k)}, {21'b0, e.fe, e.pe, e.data});
            end
          end
        end
      end
    join_none

    tick(3);
    chk("rst_vld", vld, 0);
    chk("rst_data0", d0, 0);
    chk("rst_fe", fe, 0);
    chk("rst_pe", pe, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    tick(5);

    // 8N1 0xA5 with ready held high: single-cycle valid
    vhi0 = 0;
    expect_word(0, 9'h0A5, 1'b0, 1'b0);
    send(0, 8, 9'h0A5, 0, 1'b0, 1'b1, 0, -1, -1);
    idle(0, 20);
    chk("a5_vld_cycles", vhi0, 1);

    // 7E1 0x35 has four ones: even parity bit is 0, so 1 is wrong
    expect_word(1, 9'h035, 1'b0, 1'b1);
    send(1, 7, 9'h035, 1, 1'b1, 1'b1, 0, -1, -1);
    idle(1, 20);
    expect_word(2, 9'h035, 1'b0, 1'b0);
    send(2, 7, 9'h035, 1, 1'b1, 1'b1, 0, -1, -1);
    idle(2, 20);
    expect_word(1, 9'h007, 1'b0, 1'b0);
    send(1, 7, 9'h007, 1, 1'b1, 1'b1, 0, -1, -1);
    idle(1, 20);

    // low stop bit, then a frame with no gap
    expect_word(0, 9'h03C, 1'b1, 1'b0);
    send(0, 8, 9'h03C, 0, 1'b0, 1'b0, 0, -1, -1);
    expect_word(0, 9'h011, 1'b0, 1'b0);
    send(0, 8, 9'h011, 0, 1'b0, 1'b1, 0, -1, -1);
    idle(0, 20);

    // overrun: hold 0x01, drop 0x02, accept on the cycle 0x03 completes
    rdy[0] = 1'b0;
    novr   = 0;
    expect_word(0, 9'h001, 1'b0, 1'b0);
    send(0, 8, 9'h001, 0, 1'b0, 1'b1, 0, -1, -1);
    idle(0, 4);
    chk("hold_vld", vld[0], 1);
    chk("hold_data", d0, 8'h01);
    send(0, 8, 9'h002, 0, 1'b0, 1'b1, 0, -1, -1);
    idle(0, 4);
    chk("ovr_data", d0, 8'h01);
    chk("ovr_count", novr, 1);
    expect_word(0, 9'h003, 1'b0, 1'b0);
    send(0, 8, 9'h003, 0, 1'b0, 1'b1, 0, 155, -1);
    idle(0, 20);
    chk("no_ovr_on_accept", novr, 1);
    chk("ovr_vld_clear", vld[0], 0);

    // short glitch is a false start
    line[0] = 1'b0;
    tick(4);
    idle(0, 40);
    chk("glitch_vld", vld[0], 0);

    // reset during data bit 3
    send(0, 8, 9'h0C3, 0, 1'b0, 1'b1, 0, -1, 4 * BC + 8);
    tick(2);
    chk("midrst_vld", vld, 0);
    chk("midrst_data", {d2, d1, d0}, 0);
    chk("midrst_flags", {fe, pe, ovr}, 0);
    line[0] = 1'b1;
    rst_n   = 1'b1;
    tick(20);
    expect_word(0, 9'h05A, 1'b0, 1'b0);
    send(0, 8, 9'h05A, 0, 1'b0, 1'b1, 0, -1, -1);
    idle(0, 20);

`ifdef UART_RX_MAJORITY_EN
    expect_word(0, 9'h096, 1'b0, 1'b0);
    send(0, 8, 9'h096, 0, 1'b0, 1'b1, 1, -1, -1);
    idle(0, 20);
`endif

    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
